// File: rtl/button_event_decoder.sv
// Purpose: turns a debounced button level into press/release/short/long/repeat pulses plus held level and a press counter.
// Latency: every output is registered and reacts exactly one clock after the input sample that causes it.
// Backpressure: none; pulses are single-cycle and are not stalled, so consumers must sample them every cycle.
module button_event_decoder #(
   parameter int LONG_TICKS   = 1000,
   parameter int REPEAT_TICKS = 200,
   parameter int COUNT_W      = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               debounced_in,
   output logic               press_pulse,
   output logic               release_pulse,
   output logic               short_pulse,
   output logic               long_pulse,
   output logic               repeat_pulse,
   output logic               held,
   output logic [COUNT_W-1:0] press_count
);

   localparam int MAX_TICKS = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
   localparam int CW        = $clog2(MAX_TICKS) + 1;

   // Terminal counts: counter restarts at 0 on every state change, so tick N of a phase sees N-1.
   localparam logic [CW-1:0] LONG_TC   = CW'(LONG_TICKS - 1);
   localparam logic [CW-1:0] REPEAT_TC = CW'(REPEAT_TICKS - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_PRESSED = 2'd1,
      S_REPEAT  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               press_q, press_d;
   logic               release_q, release_d;
   logic               short_q, short_d;
   logic               long_q, long_d;
   logic               repeat_q, repeat_d;
   logic               held_q, held_d;
   logic [COUNT_W-1:0] press_count_q, press_count_d;

   // Next-state and next-output logic; pulses default low so each lasts a single cycle.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      press_d       = 1'b0;
      release_d     = 1'b0;
      short_d       = 1'b0;
      long_d        = 1'b0;
      repeat_d      = 1'b0;
      held_d        = held_q;
      press_count_d = press_count_q;

      case (state_q)
         S_IDLE: begin
            held_d = 1'b0;
            if (debounced_in) begin
               state_d       = S_PRESSED;
               press_d       = 1'b1;
               held_d        = 1'b1;
               cnt_d         = '0;
               press_count_d = press_count_q + 1'b1;
            end
         end
         S_PRESSED: begin
            if (!debounced_in) begin
               // Release has priority over reaching the long-press terminal count.
               state_d   = S_IDLE;
               release_d = 1'b1;
               short_d   = 1'b1;
               held_d    = 1'b0;
            end else if (cnt_q == LONG_TC) begin
               state_d = S_REPEAT;
               long_d  = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_REPEAT: begin
            if (!debounced_in) begin
               // A release after a long press is never a short click.
               state_d   = S_IDLE;
               release_d = 1'b1;
               held_d    = 1'b0;
            end else if (cnt_q == REPEAT_TC) begin
               repeat_d = 1'b1;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            // Unused encoding: recover to idle quietly.
            state_d = S_IDLE;
            cnt_d   = '0;
            held_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset clears everything without a clock and emits no release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         press_q       <= 1'b0;
         release_q     <= 1'b0;
         short_q       <= 1'b0;
         long_q        <= 1'b0;
         repeat_q      <= 1'b0;
         held_q        <= 1'b0;
         press_count_q <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         press_q       <= press_d;
         release_q     <= release_d;
         short_q       <= short_d;
         long_q        <= long_d;
         repeat_q      <= repeat_d;
         held_q        <= held_d;
         press_count_q <= press_count_d;
      end
   end

   assign press_pulse   = press_q;
   assign release_pulse = release_q;
   assign short_pulse   = short_q;
   assign long_pulse    = long_q;
   assign repeat_pulse  = repeat_q;
   assign held          = held_q;
   assign press_count   = press_count_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Purpose: scoreboard bench for button_event_decoder with LONG_TICKS=8, REPEAT_TICKS=4, COUNT_W=2.
// Latency: expects each output vector one clock after the input sample that produced it.
// Backpressure: not applicable; the monitor samples every cycle that has a queued expectation.
module tb_button_event_decoder;

   logic       clk;
   logic       rst;
   logic       debounced_in;
   logic       press_pulse;
   logic       release_pulse;
   logic       short_pulse;
   logic       long_pulse;
   logic       repeat_pulse;
   logic       held;
   logic [1:0] press_count;

   // Output snapshot: press, release, short, long, repeat, held, press_count.
   typedef struct packed {
      logic       p;
      logic       r;
      logic       s;
      logic       l;
      logic       rp;
      logic       h;
      logic [1:0] c;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    n_checks = 0;
   int    n_pass   = 0;

   button_event_decoder #(
      .LONG_TICKS  (8),
      .REPEAT_TICKS(4),
      .COUNT_W     (2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .debounced_in (debounced_in),
      .press_pulse  (press_pulse),
      .release_pulse(release_pulse),
      .short_pulse  (short_pulse),
      .long_pulse   (long_pulse),
      .repeat_pulse (repeat_pulse),
      .held         (held),
      .press_count  (press_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t actual();
      exp_t a;
      a.p  = press_pulse;
      a.r  = release_pulse;
      a.s  = short_pulse;
      a.l  = long_pulse;
      a.rp = repeat_pulse;
      a.h  = held;
      a.c  = press_count;
      return a;
   endfunction

   task automatic check(input string name, input exp_t got, input exp_t want);
      n_checks++;
      if (got !== want)
         $display("FAIL %s: got p r s l rp h cnt = %b %b %b %b %b %b %0d, expected %b %b %b %b %b %b %0d",
                  name, got.p, got.r, got.s, got.l, got.rp, got.h, got.c,
                  want.p, want.r, want.s, want.l, want.rp, want.h, want.c);
      else
         n_pass++;
   endtask

   // Called at a falling edge: apply the input, queue the response due after the next rising edge.
   task automatic drive(input string name, input logic din,
                        input logic p, input logic r, input logic s,
                        input logic l, input logic rp, input logic h,
                        input logic [1:0] c);
      exp_t e;
      e = '{p: p, r: r, s: s, l: l, rp: rp, h: h, c: c};
      debounced_in = din;
      exp_q.push_back(e);
      name_q.push_back(name);
      @(negedge clk);
   endtask

   // Monitor: one expectation per rising edge, sampled just after the edge.
   initial begin
      exp_t  e;
      string n;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            check(n, actual(), e);
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      exp_t zero;
      zero         = '0;
      rst          = 1'b0;
      debounced_in = 1'b0;

      // Reset held with random input: all outputs zero at and between edges.
      for (int i = 0; i < 6; i++) begin
         debounced_in = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1 check("reset_after_edge", actual(), zero);
         @(negedge clk);
         check("reset_between_edges", actual(), zero);
      end
      debounced_in = 1'b0;
      rst          = 1'b1;

      // Short click: high E0..E2, low at E3.
      drive("short_e0", 1, 1, 0, 0, 0, 0, 1, 2'd1);
      drive("short_e1", 1, 0, 0, 0, 0, 0, 1, 2'd1);
      drive("short_e2", 1, 0, 0, 0, 0, 0, 1, 2'd1);
      drive("short_e3", 0, 0, 1, 1, 0, 0, 0, 2'd1);
      drive("short_idle", 0, 0, 0, 0, 0, 0, 0, 2'd1);

      // Long hold: long after E8, repeat after E12 and E16, release at E17 without short.
      for (int i = 0; i <= 16; i++)
         drive($sformatf("long_e%0d", i), 1, (i == 0), 0, 0, (i == 8),
               (i == 12 || i == 16), 1, 2'd2);
      drive("long_e17", 0, 0, 1, 0, 0, 0, 0, 2'd2);
      drive("long_idle", 0, 0, 0, 0, 0, 0, 0, 2'd2);

      // Release on the long terminal-count edge: release wins.
      for (int i = 0; i <= 7; i++)
         drive($sformatf("bound_e%0d", i), 1, (i == 0), 0, 0, 0, 0, 1, 2'd3);
      drive("bound_e8", 0, 0, 1, 1, 0, 0, 0, 2'd3);
      drive("bound_idle", 0, 0, 0, 0, 0, 0, 0, 2'd3);

      // Asynchronous reset while idle, mid-cycle, to restart the counter.
      #1 rst = 1'b0;
      #1 check("idle_reset_async", actual(), zero);
      #1 rst = 1'b1;
      @(negedge clk);

      // Wrap: five presses, count 1,2,3,0,1.
      begin
         logic [1:0] wrap_exp [5];
         wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
         for (int k = 0; k < 5; k++) begin
            drive($sformatf("wrap%0d_press", k), 1, 1, 0, 0, 0, 0, 1, wrap_exp[k]);
            drive($sformatf("wrap%0d_hold", k),  1, 0, 0, 0, 0, 0, 1, wrap_exp[k]);
            drive($sformatf("wrap%0d_rel", k),   0, 0, 1, 1, 0, 0, 0, wrap_exp[k]);
            drive($sformatf("wrap%0d_idle", k),  0, 0, 0, 0, 0, 0, 0, wrap_exp[k]);
         end
      end

      // Reset mid-hold: press then four more high cycles, then async reset mid-cycle.
      drive("mid_e0", 1, 1, 0, 0, 0, 0, 1, 2'd2);
      for (int i = 1; i <= 4; i++)
         drive($sformatf("mid_e%0d", i), 1, 0, 0, 0, 0, 0, 1, 2'd2);
      @(posedge clk);
      #3 rst = 1'b0;
      #1 check("mid_reset_async", actual(), zero);
      @(posedge clk);
      #1 check("mid_reset_no_release", actual(), zero);
      @(negedge clk);
      rst = 1'b1;
      drive("post_reset_press", 1, 1, 0, 0, 0, 0, 1, 2'd1);
      drive("post_reset_hold",  1, 0, 0, 0, 0, 0, 1, 2'd1);
      drive("post_reset_rel",   0, 0, 1, 1, 0, 0, 0, 2'd1);
      drive("post_reset_idle",  0, 0, 0, 0, 0, 0, 0, 2'd1);

      // Let the monitor drain the last expectation, then confirm nothing is left over.
      @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0)
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      else
         n_pass++;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
